uart_rx_packer: RTL and testbench

- Receives 8N1 serial bytes on `uart_rx` and packs every four bytes into one 32-bit word.
- Presents each word on a valid/ready interface that feeds the radio controller's `Tx_data`/`Tx_valid`/`Tx_ready` transmit path.
- It is the receive-side counterpart to the UART transmitter that reports radio RX bytes. It lets a host push payload words into the radio over the same serial link.

---
 rtl/proc_pkg.sv | 30 +++
 rtl/uart_rx_core.sv | 123 ++++++++++++
 rtl/uart_rx_packer.sv | 85 ++++++++
 tb/tb_uart_rx_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the UART receive packer.
// UART_RX_PARITY_EN adds an even-parity state to the receiver enum.
package proc_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned WORD_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } rx_state_t;

   // Lane 3 ([31:24]) takes byte index 0, so the first byte lands in the MSBs.
   function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] w,
                                                     input logic [7:0]        b,
                                                     input logic [1:0]        idx);
      logic [WORD_W-1:0] r;
      int unsigned       sh;
      r  = w;
      sh = 8 * (NUM_LANES - 1 - 32'(idx));
      r[sh +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchronizer, framing FSM and bit timer.
// UART_RX_PARITY_EN enables an even-parity bit checked after the data bits.
module uart_rx_core
   import proc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned    TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]  FULL_T = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]  HALF_T = TW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state;
   logic          rx_meta;
   logic          rx_s;
   logic          rx_prev;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          stop_ok;
`ifdef UART_RX_PARITY_EN
   logic          par_ok;

   assign stop_ok = rx_s & par_ok;
`else
   assign stop_ok = rx_s;
`endif

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         rx_prev    <= 1'b1;
         state      <= ST_IDLE;
         timer      <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_ok     <= 1'b0;
`endif
      end else begin
         rx_meta    <= uart_rx;
         rx_s       <= rx_meta;
         rx_prev    <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            // Only a high-to-low transition starts a frame, so a held break
            // waits here until the line idles high again.
            ST_IDLE: begin
               timer <= '0;
               if (rx_prev && !rx_s) state <= ST_START;
            end
            ST_START: begin
               if (timer == HALF_T) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_DATA: begin
               if (timer == FULL_T) begin
                  timer   <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (timer == FULL_T) begin
                  timer  <= '0;
                  par_ok <= (rx_s == ^shreg);
                  state  <= ST_STOP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`endif
            // Returns to IDLE mid stop bit so back-to-back frames are caught.
            ST_STOP: begin
               if (timer == FULL_T) begin
                  timer <= '0;
                  state <= ST_IDLE;
                  if (stop_ok) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= shreg;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes (first byte in MSBs) into 32-bit words on a valid/ready port.
// Define UART_RX_PARITY_EN for even-parity frames.
module uart_rx_packer
   import proc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   output logic [WORD_W-1:0] Tx_data,
   output logic              Tx_valid,
   input  logic              Tx_ready,
   output logic              frame_err,
   output logic              overflow,
   output logic              busy
);

   logic [7:0]        rx_byte;
   logic              byte_valid;
   logic [WORD_W-1:0] asm_word;
   logic [1:0]        byte_idx;
   logic              asm_full;

   logic [WORD_W-1:0] asm_w;
   logic [1:0]        idx_w;
   logic              full_w;
   logic              ovf_w;
   logic              load;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // The output load looks at the post-commit assembly so a fourth byte
   // reaches Tx_data one cycle after it commits.
   always_comb begin
      asm_w  = asm_word;
      idx_w  = byte_idx;
      full_w = asm_full;
      ovf_w  = 1'b0;
      if (byte_valid) begin
         if (asm_full) begin
            ovf_w = 1'b1;
         end else begin
            asm_w = lane_insert(asm_word, rx_byte, byte_idx);
            idx_w = byte_idx + 2'd1;
            if (byte_idx == 2'd3) full_w = 1'b1;
         end
      end
      load = full_w && (!Tx_valid || Tx_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_word <= '0;
         byte_idx <= '0;
         asm_full <= 1'b0;
         Tx_data  <= '0;
         Tx_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         asm_word <= asm_w;
         byte_idx <= idx_w;
         overflow <= ovf_w;
         if (load) begin
            Tx_data  <= asm_w;
            Tx_valid <= 1'b1;
            asm_full <= 1'b0;
         end else begin
            asm_full <= full_w;
            if (Tx_valid && Tx_ready) Tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed self-checking bench for uart_rx_packer at CLKS_PER_BIT=16.
// Define UART_RX_PARITY_EN to build both DUT and bench with parity frames.
module tb_uart_rx_packer;

   localparam int unsigned CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uart_rx;
   logic [31:0] Tx_data;
   logic        Tx_valid;
   logic        Tx_ready;
   logic        frame_err;
   logic        overflow;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, valid_cnt = 0, stable_err = 0, cyc = 0;
   logic [31:0] wq[$];
   int          wcyc[$];
   logic        prev_valid = 1'b0, prev_ready = 1'b0;
   logic [31:0] prev_data = '0;

   uart_rx_packer #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .Tx_data  (Tx_data),
      .Tx_valid (Tx_valid),
      .Tx_ready (Tx_ready),
      .frame_err(frame_err),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (frame_err) fe_cnt++;
         if (overflow)  ov_cnt++;
         if (busy)      busy_cnt++;
         if (Tx_valid)  valid_cnt++;
         if (Tx_valid && Tx_ready) begin
            wq.push_back(Tx_data);
            wcyc.push_back(cyc);
         end
         if (prev_valid && !prev_ready && (!Tx_valid || Tx_data !== prev_data)) stable_err++;
      end
      prev_valid = Tx_valid;
      prev_ready = Tx_ready;
      prev_data  = Tx_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      uart_rx = b;
      tick(CPB);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`else
      if (par_flip) uart_rx = 1'b1;
`endif
      send_bit(stop_b);
   endtask

   function automatic logic [31:0] word_at(input int k);
      return (k < wq.size()) ? wq[k] : 32'hxxxx_xxxx;
   endfunction

   initial begin
      int base, fe0, ov0, vc0, bc0;

      rst_n    = 1'b0;
      uart_rx  = 1'b1;
      Tx_ready = 1'b1;
      tick(3);
      check("rst_data",  Tx_data,   32'h0);
      check("rst_valid", {31'd0, Tx_valid},  32'd0);
      check("rst_fe",    {31'd0, frame_err}, 32'd0);
      check("rst_ovf",   {31'd0, overflow},  32'd0);
      check("rst_busy",  {31'd0, busy},      32'd0);
      rst_n = 1'b1;
      tick(5);

      // Basic packing
      base = wq.size(); fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cnt;
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      send_byte(8'h33, 1'b1, 1'b0);
      send_byte(8'h44, 1'b1, 1'b0);
      tick(20);
      check("basic_nwords", 32'(wq.size() - base), 32'd1);
      check("basic_word",   word_at(base),         32'h11223344);
      check("basic_vcyc",   32'(valid_cnt - vc0),  32'd1);
      check("basic_fe",     32'(fe_cnt - fe0),     32'd0);
      check("basic_ovf",    32'(ov_cnt - ov0),     32'd0);

      // Backpressure and overflow
      Tx_ready = 1'b0;
      base = wq.size(); ov0 = ov_cnt;
      for (int b = 1; b <= 12; b++) send_byte(8'(b), 1'b1, 1'b0);
      tick(20);
      check("bp_valid",    {31'd0, Tx_valid},       32'd1);
      check("bp_data",     Tx_data,                 32'h01020304);
      check("bp_pending",  {31'd0, dut.asm_full},   32'd1);
      check("bp_asm",      dut.asm_word,            32'h05060708);
      check("bp_ovf",      32'(ov_cnt - ov0),       32'd4);
      check("bp_nwords",   32'(wq.size() - base),   32'd0);
      check("bp_stable",   32'(stable_err),         32'd0);
      Tx_ready = 1'b1;
      tick(6);
      check("bp_nwords2",  32'(wq.size() - base),   32'd2);
      check("bp_w0",       word_at(base),           32'h01020304);
      check("bp_w1",       word_at(base + 1),       32'h05060708);
      check("bp_b2b",      (wq.size() >= base + 2) ? 32'(wcyc[base+1] - wcyc[base]) : 32'hffff_ffff, 32'd1);
      check("bp_drained",  {31'd0, Tx_valid},       32'd0);
      check("bp_idx",      {30'd0, dut.byte_idx},   32'd0);

      // Bad stop bit
      fe0 = fe_cnt; base = wq.size();
      send_byte(8'h55, 1'b0, 1'b0);
      uart_rx = 1'b1;
      tick(3 * CPB);
      check("fe_pulse",    32'(fe_cnt - fe0),       32'd1);
      check("fe_idx",      {30'd0, dut.byte_idx},   32'd0);
      send_byte(8'hA1, 1'b1, 1'b0);
      send_byte(8'hB2, 1'b1, 1'b0);
      send_byte(8'hC3, 1'b1, 1'b0);
      send_byte(8'hD4, 1'b1, 1'b0);
      tick(20);
      check("fe_word",     word_at(base),           32'hA1B2C3D4);
      check("fe_nwords",   32'(wq.size() - base),   32'd1);
      check("fe_no_more",  32'(fe_cnt - fe0),       32'd1);

      // Glitch rejection
      fe0 = fe_cnt; base = wq.size(); bc0 = busy_cnt;
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      tick(40);
      check("gl_busy_seen", {31'd0, (busy_cnt - bc0 > 0) && (busy_cnt - bc0 <= int'(CPB))}, 32'd1);
      check("gl_busy_end",  {31'd0, busy},            32'd0);
      check("gl_fe",        32'(fe_cnt - fe0),        32'd0);
      check("gl_nwords",    32'(wq.size() - base),    32'd0);
      check("gl_idx",       {30'd0, dut.byte_idx},    32'd0);

      // Reset mid-frame: one full byte, then part of the second
      send_byte(8'hAA, 1'b1, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      tick(2);
      check("mr_data",  Tx_data,                 32'h0);
      check("mr_valid", {31'd0, Tx_valid},       32'd0);
      check("mr_busy",  {31'd0, busy},           32'd0);
      check("mr_fe",    {31'd0, frame_err},      32'd0);
      check("mr_ovf",   {31'd0, overflow},       32'd0);
      check("mr_idx",   {30'd0, dut.byte_idx},   32'd0);
      rst_n = 1'b1;
      tick(20);
      base = wq.size();
      send_byte(8'h5A, 1'b1, 1'b0);
      send_byte(8'h6B, 1'b1, 1'b0);
      send_byte(8'h7C, 1'b1, 1'b0);
      send_byte(8'h8D, 1'b1, 1'b0);
      tick(20);
      check("mr_word",   word_at(base),         32'h5A6B7C8D);
      check("mr_nwords", 32'(wq.size() - base), 32'd1);

`ifdef UART_RX_PARITY_EN
      // 0x03 has two ones, so correct even parity is 0
      fe0 = fe_cnt; base = wq.size();
      send_byte(8'h03, 1'b1, 1'b1);
      uart_rx = 1'b1;
      tick(CPB);
      check("par_bad_fe", 32'(fe_cnt - fe0),       32'd1);
      check("par_idx",    {30'd0, dut.byte_idx},   32'd0);
      send_byte(8'h03, 1'b1, 1'b0);
      send_byte(8'h04, 1'b1, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      send_byte(8'h06, 1'b1, 1'b0);
      tick(20);
      check("par_word",   word_at(base),           32'h03040506);
      check("par_fe_tot", 32'(fe_cnt - fe0),       32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
